// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, the R0 index and the writeback sequencer states.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned R0_IDX = 0;

  localparam logic [CTRL_W-1:0] ALU_ADD   = 4'h1;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 4'h2;
  localparam logic [CTRL_W-1:0] ALU_MUL   = 4'h4;
  localparam logic [CTRL_W-1:0] ALU_DIV   = 4'h8;
  localparam logic [CTRL_W-1:0] ALU_ANDI  = 4'hC;
  localparam logic [CTRL_W-1:0] ALU_ORI   = 4'hE;
  localparam logic [CTRL_W-1:0] ALU_ADDNF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_R0 = 2'd1,
    ST_EXC   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/alu_op_classify.sv
// Decodes an ALU op code into arithmetic / dual-write / register-write classes.
module alu_op_classify
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  output logic              is_arith_c,
  output logic              is_dual_c,
  output logic              is_write_c
);

  always_comb begin
    is_dual_c  = (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
    is_arith_c = is_dual_c || (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_ADDNF);
    is_write_c = is_arith_c || (ctrl == ALU_ANDI) || (ctrl == ALU_ORI);
  end

endmodule

// File: rtl/alu_wb_sequencer.sv
// ALU writeback: drives the single register-file write port, serialises the
// Rd/R0 pair of mul/div and parks on arithmetic overflow until acknowledged.
module alu_wb_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned R0_ADDR = R0_IDX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [3:0]        ctrl,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_r0,
  input  logic              ovf_in,
  input  logic [15:0]       pc_in,
  input  logic              exc_ack,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              exc_req,
  output logic [15:0]       exc_pc
);

  localparam logic [ADDR_W-1:0] R0_A = ADDR_W'(R0_ADDR);

  wb_state_e         state_q;
  logic [DATA_W-1:0] r0_q;
  logic              is_arith_c;
  logic              is_dual_c;
  logic              is_write_c;

  alu_op_classify u_classify (
    .ctrl       (ctrl),
    .is_arith_c (is_arith_c),
    .is_dual_c  (is_dual_c),
    .is_write_c (is_write_c)
  );

  // Any non-idle state means upstream must hold its result registers.
  assign stall = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      r0_q     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      exc_req  <= 1'b0;
      exc_pc   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rf_we <= 1'b0;
          if (valid_in) begin
            if (is_arith_c && ovf_in) begin
              exc_req <= 1'b1;
              exc_pc  <= pc_in;
              state_q <= ST_EXC;
            end else if (is_dual_c && (rd_addr == R0_A)) begin
              // Rd aliases R0: only one write, and the R0 result takes priority.
              rf_we    <= 1'b1;
              rf_waddr <= R0_A;
              rf_wdata <= alu_r0;
            end else if (is_dual_c) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd_addr;
              rf_wdata <= alu_out;
              r0_q     <= alu_r0;
              state_q  <= ST_WR_R0;
            end else if (is_write_c) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd_addr;
              rf_wdata <= alu_out;
            end
          end
        end
        ST_WR_R0: begin
          rf_we    <= 1'b1;
          rf_waddr <= R0_A;
          rf_wdata <= r0_q;
          state_q  <= ST_IDLE;
        end
        ST_EXC: begin
          rf_we <= 1'b0;
          if (exc_ack) begin
            exc_req <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          rf_we   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_wb_sequencer.md
Name: alu_wb_sequencer

Overview:
Writeback stage directly downstream of the 16-bit ALU. It takes the ALU result, the R0 side result (multiply high half or divide remainder) and the overflow flag, and drives the register file's single write port. Multiply and divide need two writes (Rd and R0), so the block serialises them and stalls upstream for one cycle. Arithmetic overflow squashes the write and raises an exception request that is held until the handler acknowledges it.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 4, register address width
R0_ADDR, 0, register file index of R0

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, synchronous, active-low
valid_in  input  1  ALU result valid this cycle
ctrl  input  4  ALU op code (1 add, 2 sub, 4 mul, 8 div, C andi, E ori, F add-nofunc)
rd_addr  input  ADDR_W  destination register
alu_out  input  DATA_W  ALU primary result
alu_r0  input  DATA_W  ALU R0 result (mul high / div remainder)
ovf_in  input  1  ALU overflow flag
pc_in  input  16  PC of the instruction being retired
exc_ack  input  1  exception handler acknowledge
stall  output  1  upstream must hold; combinational, equals (state != IDLE)
rf_we  output  1  register file write enable (registered)
rf_waddr  output  ADDR_W  write address (registered)
rf_wdata  output  DATA_W  write data (registered)
exc_req  output  1  overflow exception pending (registered)
exc_pc  output  16  PC of the faulting instruction (registered)

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE; rf_we, rf_waddr, rf_wdata, exc_req, exc_pc all 0; latched R0 value cleared. Reset overrides every state. Reset during WR_R0 aborts the pending R0 write. Reset during EXC drops exc_req.
- Op classes:
  - ARITH = {1,2,4,8,F}.
  - DUAL = {4,8}.
  - WRITE = {1,2,4,8,C,E,F}.
  - Any other ctrl value is a valid no-write bubble: rf_we=0, no exception.
- Overflow is honoured only for ARITH. ovf_in is ignored for C and E.
- IDLE, valid_in=1, cycle N; effect at edge ending N:
  - ARITH and ovf_in=1: rf_we<=0; exc_req<=1; exc_pc<=pc_in; state<=EXC. No register is written, including R0.
  - DUAL, no overflow, rd_addr!=R0_ADDR: rf_we<=1, rf_waddr<=rd_addr, rf_wdata<=alu_out; latch alu_r0; state<=WR_R0.
  - DUAL, no overflow, rd_addr==R0_ADDR: single write rf_waddr<=R0_ADDR, rf_wdata<=alu_r0 (R0 result wins); state stays IDLE.
  - Other WRITE op: rf_we<=1, rf_waddr<=rd_addr, rf_wdata<=alu_out; stays IDLE.
- IDLE, valid_in=0: rf_we<=0.
- WR_R0 (cycle N+1, stall=1): inputs ignored. At the edge: rf_we<=1, rf_waddr<=R0_ADDR, rf_wdata<=latched r0; state<=IDLE. New input is accepted at N+2. Each DUAL op costs exactly 1 stall cycle.
- EXC: stall=1, rf_we<=0, exc_req and exc_pc held. exc_ack=1 sampled at an edge -> exc_req<=0, state<=IDLE, accept from the next cycle. exc_ack seen in IDLE or WR_R0 is ignored.
- valid_in asserted while stall=1 is ignored. Upstream holds its registers.
- Write data is taken unmodified from ALU (two's complement 16-bit). No sign manipulation.

Decomposition:
- Shared package alu_pkg:
  - ctrl op code constants (ALU_ADD=4'h1, ALU_SUB=4'h2, ALU_MUL=4'h4, ALU_DIV=4'h8, ALU_ANDI=4'hC, ALU_ORI=4'hE, ALU_ADDNF=4'hF)
  - R0 index constant
  - 2-bit state enum {IDLE, WR_R0, EXC}
- One small combinational sub-module, alu_op_classify: ctrl -> is_arith, is_dual, is_write. It is reused by hazard/forwarding logic.

Test Plan:
- add: ctrl=1, rd=3, alu_out=0x0005, ovf=0 -> next cycle rf_we=1, waddr=3, wdata=0x0005; stall never asserts.
- mul: ctrl=4, rd=2, alu_out=0x2000, alu_r0=0x0001 -> cycle N+1: write R2=0x2000, stall=1. Cycle N+2: write R0=0x0001, stall=0. A second add offered at N+1 is ignored and accepted at N+2.
- div with rd=0: ctrl=8, alu_out=0x0003, alu_r0=0x0002 -> single write R0=0x0002, no stall.
- Overflow: ctrl=1, ovf=1, pc_in=0x0040 -> rf_we=0, exc_req=1, exc_pc=0x0040, stall held for 5 cycles. exc_ack pulse -> exc_req=0 next cycle, then an ori to R4 writes normally.
- ori with ovf_in=1: ctrl=E, rd=5, alu_out=0x00FF -> writes R5=0x00FF, no exception. ctrl=D -> rf_we=0.
- Reset mid-op: mul accepted, reset=0 during WR_R0 -> no R0 write, all outputs 0, state IDLE, stall=0.
